// File: rtl/keccak_byte_packer_pkg.sv
// Shared types and constants for the keccak byte packer.
package keccak_byte_packer_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Moves the n least-significant bytes of w to the top of the word and zero-fills the rest.
   // The first byte of the group lands in [31:24].
   function automatic logic [WORD_W-1:0] left_align(input logic [WORD_W-1:0] w,
                                                    input logic [2:0]        n);
      int sh;
      sh = WORD_W - BYTE_W * int'(n);
      return w << sh;
   endfunction

endpackage

// File: rtl/keccak_byte_packer.sv
// Packs a byte stream big-endian into 32-bit words for the keccak core,
// one message per reset, with the core's buffer_full backpressure.
//
// Handshakes: a byte (or a flush) is taken on a rising edge when byte_ready is
// high together with byte_valid (or flush with byte_valid low). A word moves
// to the core on a rising edge when in_ready is high and buffer_full is low;
// while in_ready is high and buffer_full is high, in/is_last/byte_num hold.
module keccak_byte_packer
   import keccak_byte_packer_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              byte_valid,
   input  logic              byte_last,
   input  logic              flush,
   output logic              byte_ready,
   output logic [WORD_W-1:0] in,
   output logic              in_ready,
   output logic              is_last,
   output logic [1:0]        byte_num,
   input  logic              buffer_full,
   output logic              msg_done,
   output logic [LEN_W-1:0]  msg_len
);

   state_t      state;
   logic [23:0] acc;
   logic [1:0]  cnt;

   logic xfer;
   logic slot_free;
   logic byte_acc;
   logic flush_acc;
   logic load;

   // Handshake terms; byte_ready is combinational from buffer_full so a word
   // leaving and a byte arriving can share a cycle.
   always_comb begin
      xfer       = in_ready & ~buffer_full;
      slot_free  = ~in_ready | ~buffer_full;
      byte_ready = (state == FILL) & slot_free;
      byte_acc   = byte_valid & byte_ready;
      flush_acc  = flush & ~byte_valid & byte_ready;
      load       = ((state == FILL) & ((byte_acc & ((cnt == 2'd3) | byte_last)) | flush_acc))
                 | ((state == FLUSH) & slot_free);
   end

   // Packing FSM, output word register, completion flag and length counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FILL;
         acc      <= '0;
         cnt      <= '0;
         in       <= '0;
         in_ready <= 1'b0;
         is_last  <= 1'b0;
         byte_num <= '0;
         msg_done <= 1'b0;
         msg_len  <= '0;
      end else begin
         if (xfer && is_last)
            msg_done <= 1'b1;

         if (byte_acc && (msg_len != {LEN_W{1'b1}}))
            msg_len <= msg_len + 1'b1;

         if (load)
            in_ready <= 1'b1;
         else if (xfer)
            in_ready <= 1'b0;

         case (state)
            FILL: begin
               if (byte_acc) begin
                  if (cnt != 2'd3 && !byte_last) begin
                     acc <= {acc[15:0], byte_in};
                     cnt <= cnt + 2'd1;
                  end else if (cnt == 2'd3) begin
                     // Full word; a last byte here still needs an empty terminator word.
                     in       <= {acc, byte_in};
                     is_last  <= 1'b0;
                     byte_num <= 2'd0;
                     cnt      <= 2'd0;
                     if (byte_last)
                        state <= FLUSH;
                  end else begin
                     in       <= left_align({acc, byte_in}, {1'b0, cnt} + 3'd1);
                     is_last  <= 1'b1;
                     byte_num <= cnt + 2'd1;
                     cnt      <= 2'd0;
                     state    <= DONE;
                  end
               end else if (flush_acc) begin
                  in       <= left_align({8'h00, acc}, {1'b0, cnt});
                  is_last  <= 1'b1;
                  byte_num <= cnt;
                  cnt      <= 2'd0;
                  state    <= DONE;
               end
            end
            FLUSH: begin
               if (slot_free) begin
                  in       <= '0;
                  is_last  <= 1'b1;
                  byte_num <= 2'd0;
                  state    <= DONE;
               end
            end
            DONE: begin
               // Message complete; inputs ignored until reset.
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Self-checking bench for keccak_byte_packer: directed messages, expected
// words queued at issue time and checked by an independent monitor.
module tb_keccak_byte_packer;
   import keccak_byte_packer_pkg::*;

   localparam int LEN_W = 16;

   logic              clk;
   logic              reset;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_last;
   logic              flush;
   logic              byte_ready;
   logic [31:0]       in;
   logic              in_ready;
   logic              is_last;
   logic [1:0]        byte_num;
   logic              buffer_full;
   logic              msg_done;
   logic [LEN_W-1:0]  msg_len;

   int checks = 0;
   int errors = 0;

   // {is_last, byte_num, word}
   logic [34:0] exp_q[$];

   keccak_byte_packer #(.LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_last(byte_last), .flush(flush), .byte_ready(byte_ready), .in(in),
      .in_ready(in_ready), .is_last(is_last), .byte_num(byte_num),
      .buffer_full(buffer_full), .msg_done(msg_done), .msg_len(msg_len)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_word(input logic [31:0] w, input logic last, input logic [1:0] bn);
      exp_q.push_back({last, bn, w});
   endtask

   // monitor: a word is taken on the next rising edge when in_ready & !buffer_full
   initial begin
      logic [34:0] e;
      forever begin
         @(negedge clk);
         if (!reset && in_ready && !buffer_full) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", {31'd0, is_last, byte_num, in}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("word", {32'd0, in}, {32'd0, e[31:0]});
               chk("is_last", {63'd0, is_last}, {63'd0, e[34]});
               chk("byte_num", {62'd0, byte_num}, {62'd0, e[33:32]});
               if (e[34]) begin
                  chk("msg_done_before", {63'd0, msg_done}, 64'd0);
                  @(negedge clk);
                  chk("msg_done_after", {63'd0, msg_done}, 64'd1);
               end
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      byte_valid = 1'b0;
      byte_last = 1'b0;
      flush = 1'b0;
      byte_in = 8'h00;
      buffer_full = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in", {32'd0, in}, 64'd0);
      chk("rst_flags", {60'd0, in_ready, is_last, msg_done, byte_ready}, 64'd1);
      chk("rst_byte_num", {62'd0, byte_num}, 64'd0);
      chk("rst_msg_len", {48'd0, msg_len}, 64'd0);
      @(posedge clk); #1;
   endtask

   // driver: hold a byte until accepted (bounded)
   task automatic send_byte(input logic [7:0] b, input logic last);
      int n;
      logic ok;
      byte_in = b;
      byte_last = last;
      byte_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         ok = byte_ready;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 200);
      if (!ok) chk("byte_accept_timeout", 64'd0, 64'd1);
      byte_valid = 1'b0;
      byte_last = 1'b0;
   endtask

   task automatic send_str(input string s, input logic last_at_end);
      for (int i = 0; i < s.len(); i++)
         send_byte(s[i], last_at_end && (i == s.len() - 1));
   endtask

   task automatic send_flush();
      int n;
      logic ok;
      flush = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         ok = byte_ready;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 200);
      if (!ok) chk("flush_accept_timeout", 64'd0, 64'd1);
      flush = 1'b0;
   endtask

   // wait for all queued words and msg_done, then check the length
   task automatic drain(input int exp_len);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !msg_done) && n < 300) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain_queue_empty", exp_q.size(), 64'd0);
      chk("drain_msg_done", {63'd0, msg_done}, 64'd1);
      chk("msg_len", {48'd0, msg_len}, exp_len);
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; byte_valid = 1'b0; byte_last = 1'b0; flush = 1'b0;
      byte_in = 8'h00; buffer_full = 1'b0;
      repeat (2) @(posedge clk);

      // Hello, world!
      do_reset();
      expect_word(32'h48656C6C, 1'b0, 2'd0);
      expect_word(32'h6F2C2077, 1'b0, 2'd0);
      expect_word(32'h6F726C64, 1'b0, 2'd0);
      expect_word(32'h21000000, 1'b1, 2'd1);
      send_str("Hello, world!", 1'b1);
      drain(13);

      // inputs ignored in DONE
      byte_in = 8'hAA; byte_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("done_byte_ready_a", {63'd0, byte_ready}, 64'd0);
      @(posedge clk); #1;
      byte_valid = 1'b0;
      @(negedge clk);
      chk("done_byte_ready_b", {63'd0, byte_ready}, 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      repeat (2) @(negedge clk);
      chk("done_in", {32'd0, in}, 64'h21000000);
      chk("done_flags", {61'd0, in_ready, is_last, msg_done}, 64'd3);
      chk("done_byte_num", {62'd0, byte_num}, 64'd1);
      chk("done_msg_len", {48'd0, msg_len}, 64'd13);
      @(posedge clk); #1;

      // The quick brown fox. (ends on a word boundary)
      do_reset();
      expect_word(32'h54686520, 1'b0, 2'd0);
      expect_word(32'h71756963, 1'b0, 2'd0);
      expect_word(32'h6B206272, 1'b0, 2'd0);
      expect_word(32'h6F776E20, 1'b0, 2'd0);
      expect_word(32'h666F782E, 1'b0, 2'd0);
      expect_word(32'h00000000, 1'b1, 2'd0);
      send_str("The quick brown fox.", 1'b1);
      drain(20);

      // 1234567890 with backpressure on the second word
      do_reset();
      expect_word(32'h31323334, 1'b0, 2'd0);
      expect_word(32'h35363738, 1'b0, 2'd0);
      expect_word(32'h39300000, 1'b1, 2'd2);
      send_str("12345678", 1'b0);
      buffer_full = 1'b1;
      fork
         send_str("90", 1'b1);
         begin
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk("stall_in", {32'd0, in}, 64'h35363738);
               chk("stall_in_ready", {63'd0, in_ready}, 64'd1);
               chk("stall_byte_ready", {63'd0, byte_ready}, 64'd0);
               chk("stall_msg_len", {48'd0, msg_len}, 64'd8);
            end
            @(posedge clk); #1;
            buffer_full = 1'b0;
         end
      join
      drain(10);

      // empty message
      do_reset();
      expect_word(32'h00000000, 1'b1, 2'd0);
      send_flush();
      drain(0);

      // reset mid-message discards partial bytes
      do_reset();
      send_str("xy", 1'b0);
      do_reset();
      expect_word(32'h70617373, 1'b0, 2'd0);
      expect_word(32'h00000000, 1'b1, 2'd0);
      send_str("pass", 1'b1);
      drain(4);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // global time limit
   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
